bus_arbiter: RTL and testbench

Sequential arbiter that shares the single system bus (address, databus, read, write) between the processor and up to NCH DMA requesters. The processor owns the bus by default. The arbiter collects DMA channel requests and runs a hold/acknowledge handshake with the processor. It then grants the bus to one channel at a time in round-robin order, with a per-grant burst limit. It sits between the processor, the dma block(s) and the ram/io1/io2 slaves, and drives only control signals, never bus data.

---
 rtl/bus_arbiter.sv | 124 ++++++++++++
 tb/tb_bus_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin DMA bus arbiter with processor hold/ack handshake and burst limit
`timescale 1ns/1ps
module bus_arbiter #(
  parameter int NCH       = 4,
  parameter int MAX_BURST = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [NCH-1:0] dreq,
  input  logic           word_done,
  input  logic           chan_done,
  input  logic           hold_ack,
  output logic           hold_req,
  output logic           cpu_grant,
  output logic [NCH-1:0] dgrant,
  output logic [NCH-1:0] ddone,
  output logic           busy
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, HOLD, GRANT, RELEASE} state_t;

  state_t         state, state_n;
  logic [PW-1:0]  rr_ptr, rr_n;
  logic [PW-1:0]  gidx, gidx_n;
  logic [PW-1:0]  win_idx, cidx, gnext;
  logic [BW-1:0]  burst_cnt, cnt_n, cnt_inc;
  logic [NCH-1:0] dgrant_n, ddone_n;
  logic           win_any, leave;

  // First requesting channel at or after rr_ptr, wrapping modulo NCH.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    cidx    = '0;
    for (int i = 0; i < NCH; i++) begin
      cidx = PW'((int'(rr_ptr) + i) % NCH);
      if (!win_any && dreq[cidx]) begin
        win_any = 1'b1;
        win_idx = cidx;
      end
    end
  end

  // Saturating word count, so a word arriving with chan_done is still counted.
  assign cnt_inc = (word_done && burst_cnt != BW'(MAX_BURST)) ? burst_cnt + BW'(1) : burst_cnt;
  assign gnext   = (gidx == PW'(NCH - 1)) ? '0 : gidx + PW'(1);

  always_comb begin
    state_n  = state;
    rr_n     = rr_ptr;
    gidx_n   = gidx;
    cnt_n    = burst_cnt;
    dgrant_n = dgrant;
    ddone_n  = '0;
    leave    = 1'b0;
    case (state)
      IDLE: begin
        if (|dreq) state_n = HOLD;
      end
      HOLD: begin
        if (!win_any) begin
          state_n = RELEASE;
        end else if (hold_ack) begin
          state_n  = GRANT;
          gidx_n   = win_idx;
          dgrant_n = NCH'(1) << win_idx;
          cnt_n    = '0;
        end
      end
      GRANT: begin
        cnt_n = cnt_inc;
        // Lost ack outranks everything: the bus is no longer ours, so no ddone.
        if (!hold_ack) begin
          leave = 1'b1;
        end else if (chan_done) begin
          leave   = 1'b1;
          ddone_n = dgrant;
        end else if (!dreq[gidx]) begin
          leave = 1'b1;
        end else if (cnt_inc == BW'(MAX_BURST)) begin
          leave = 1'b1;
        end
        if (leave) begin
          state_n  = RELEASE;
          dgrant_n = '0;
          cnt_n    = '0;
          rr_n     = gnext;
        end
      end
      RELEASE: begin
        if (!hold_ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gidx      <= '0;
      burst_cnt <= '0;
      dgrant    <= '0;
      ddone     <= '0;
      hold_req  <= 1'b0;
      cpu_grant <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      rr_ptr    <= rr_n;
      gidx      <= gidx_n;
      burst_cnt <= cnt_n;
      dgrant    <= dgrant_n;
      ddone     <= ddone_n;
      hold_req  <= (state_n == HOLD) || (state_n == GRANT);
      cpu_grant <= (state_n == IDLE);
      busy      <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed self-checking bench for bus_arbiter
`timescale 1ns/1ps
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] dreq;
  logic       word_done, chan_done, hold_ack;
  logic       hold_req, cpu_grant, busy;
  logic [3:0] dgrant, ddone;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [3:0] rr_order [4];

  bus_arbiter #(.NCH(4), .MAX_BURST(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .dreq      (dreq),
    .word_done (word_done),
    .chan_done (chan_done),
    .hold_ack  (hold_ack),
    .hold_req  (hold_req),
    .cpu_grant (cpu_grant),
    .dgrant    (dgrant),
    .ddone     (ddone),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic hr, input logic cg, input logic bz,
                     input logic [3:0] dg, input logic [3:0] dd);
    logic [10:0] obs, exp;
    obs = {hold_req, cpu_grant, busy, dgrant, ddone};
    exp = {hr, cg, bz, dg, dd};
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (hold_req,cpu_grant,busy,dgrant,ddone)", tag, obs, exp);
    end
  endtask

  // From IDLE with dreq already set: one edge to HOLD, processor acks, one edge to GRANT.
  task automatic grant_seq(input string tag, input logic [3:0] exp_dg);
    tick();
    chk({tag, " hold"}, 1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000);
    hold_ack = 1'b1;
    tick();
    chk({tag, " grant"}, 1'b1, 1'b0, 1'b1, exp_dg, 4'b0000);
  endtask

  task automatic release_seq(input string tag);
    hold_ack = 1'b0;
    tick();
    chk({tag, " idle"}, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
  endtask

  task automatic words(input int n);
    word_done = 1'b1;
    repeat (n) tick();
    word_done = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; dreq = '0; word_done = 1'b0; chan_done = 1'b0; hold_ack = 1'b0;
    rr_order[0] = 4'b0001; rr_order[1] = 4'b0010; rr_order[2] = 4'b1000; rr_order[3] = 4'b0001;
    repeat (2) tick();
    chk("reset", 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
    reset_n = 1'b1;
    tick();
    chk("idle no req", 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);

    // Single request on ch2, 3 words then completion.
    dreq = 4'b0100;
    grant_seq("t1", 4'b0100);
    words(3);
    chk("t1 words", 1'b1, 1'b0, 1'b1, 4'b0100, 4'b0000);
    chan_done = 1'b1;
    tick();
    chan_done = 1'b0;
    chk("t1 done", 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0100);
    dreq = '0;
    tick();
    chk("t1 ddone once", 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
    release_seq("t1");

    // Burst preemption: pointer now 3, so ch0 wins over ch1.
    dreq = 4'b0011;
    grant_seq("burst", 4'b0001);
    words(7);
    chk("burst 7 words", 1'b1, 1'b0, 1'b1, 4'b0001, 4'b0000);
    words(1);
    chk("burst preempt", 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
    release_seq("burst");
    grant_seq("burst next", 4'b0010);

    // Abort: ch1 drops its request after 2 words.
    words(2);
    chk("abort words", 1'b1, 1'b0, 1'b1, 4'b0010, 4'b0000);
    dreq = 4'b0001;
    tick();
    chk("abort", 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
    tick();
    chk("abort release", 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
    release_seq("abort");

    // 8th word coincides with chan_done: completion, not preemption.
    grant_seq("sim", 4'b0001);
    words(7);
    word_done = 1'b1; chan_done = 1'b1;
    tick();
    word_done = 1'b0; chan_done = 1'b0;
    chk("sim done", 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0001);
    dreq = '0;
    tick();
    chk("sim single pulse", 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
    release_seq("sim");

    // Pointer is 1, so ch1 wins; reset mid-grant returns the pointer to 0.
    dreq = 4'b1011;
    grant_seq("pre-rst", 4'b0010);
    words(1);
    reset_n = 1'b0;
    #1;
    chk("rst async", 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
    hold_ack = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("rst held", 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);

    for (int k = 0; k < 4; k++) begin
      grant_seq($sformatf("rr%0d", k), rr_order[k]);
      words(1);
      chan_done = 1'b1;
      tick();
      chan_done = 1'b0;
      chk($sformatf("rr%0d done", k), 1'b0, 1'b0, 1'b1, 4'b0000, rr_order[k]);
      release_seq($sformatf("rr%0d", k));
    end

    // Processor drops hold_ack while ch1 is granted.
    dreq = 4'b0010;
    grant_seq("perr", 4'b0010);
    hold_ack = 1'b0;
    tick();
    chk("perr drop", 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000);
    tick();
    chk("perr idle", 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
    dreq = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
